// File: rtl/mem_dump_reader_if.sv
// Memory read port and output byte stream of the dump reader.
//   mem_rd / mem_addr   : read strobe and address towards the data memory
//   mem_rdata           : read data, valid the cycle after mem_rd
//   out_valid / out_ready : stream handshake
//   out_data / out_addr : stream byte and the address it was read from
// master = dump reader side, slave = memory + stream consumer side.
interface mem_dump_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_ready;

    modport master (
        output mem_rd, mem_addr, out_valid, out_data, out_addr,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, out_valid, out_data, out_addr,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Reads a block of data memory and streams it out one byte at a time,
// tagging each byte with the address it came from.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : dump request, only looked at while idle
//   start_addr : first address of the dump
//   length     : byte count 0..2^ADDR_W (larger values are clamped)
//   bus        : memory read port + output stream (mem_dump_reader_if.master)
//   busy       : high whenever not idle
//   done       : one-cycle pulse at the end of each dump
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start
// READ    | mem_rd asserted for the current address
// CAPTURE | memory data arrives, loaded into the output
// HOLD    | byte offered downstream until accepted
// FINISH  | done pulse, back to IDLE
module mem_dump_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     length,
    mem_dump_reader_if.master   bus,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_HOLD,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W:0]   len_clamped;
    logic              xfer;
    logic              mem_rd_c;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign xfer        = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd_c  = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (length != '0) ? S_READ : S_FINISH;
                end
            end
            S_READ: begin
                mem_rd_c  = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // remaining was already decremented when this byte was captured
                if (xfer) begin
                    state_nxt = (remaining != '0) ? S_READ : S_FINISH;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr        <= '0;
            remaining   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= len_clamped;
                    end
                end
                S_CAPTURE: begin
                    out_data_q  <= bus.mem_rdata;
                    out_addr_q  <= addr;
                    out_valid_q <= 1'b1;
                    remaining   <= remaining - 1'b1;
                    addr        <= addr + 1'b1;
                end
                S_HOLD: begin
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_addr  = mem_rd_c ? addr : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
module tb_mem_dump_reader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;

    mem_dump_reader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_dump_reader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // memory: registered read, data valid the cycle after mem_rd
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // downstream ready: 0 = always ready, 1 = random, 2 = stall first byte 5 cycles
    int rdy_mode = 0;
    int bp_cnt   = 0;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bus.out_valid && bp_cnt < 5) begin
                    bus.out_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    bus.out_ready = (bp_cnt >= 5);
                end
            end
        endcase
    end

    // reference model: expected (addr,data) stream, and what was observed
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    bit          seen [256];

    int cyc = 0;
    int rd_cnt, done_cnt, busy_cnt, stall_cnt;
    int last_rd_cyc, first_rd_cyc, done_cyc, last_hs_cyc, start_cyc;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data, prev_addr;

    always @(negedge clk) begin
        logic [15:0] e;
        cyc++;
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.mem_rd) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                check("addr_read_once", int'(seen[bus.mem_addr]), 0);
                seen[bus.mem_addr] = 1'b1;
            end
            if (bus.mem_rd || bus.out_valid || done) check("busy_when_active", int'(busy), 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (bus.out_valid && !prev_valid) check("read_to_valid_latency", cyc - last_rd_cyc, 2);
            if (prev_valid && !prev_ready) begin
                check("valid_held", int'(bus.out_valid), 1);
                if (bus.out_valid) begin
                    check("data_stable", int'(bus.out_data), int'(prev_data));
                    check("addr_stable", int'(bus.out_addr), int'(prev_addr));
                end
            end
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_addr", int'(bus.out_addr), int'(e[15:8]));
                    check("out_data", int'(bus.out_data), int'(e[7:0]));
                end
                obs_q.push_back({bus.out_addr, bus.out_data});
                if (rdy_mode == 0 && last_hs_cyc >= 0) check("throughput", cyc - last_hs_cyc, 3);
                last_hs_cyc = cyc;
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
            prev_addr  = bus.out_addr;
        end
    end

    task automatic init_dump(input int mode);
        rd_cnt       = 0;
        done_cnt     = 0;
        busy_cnt     = 0;
        stall_cnt    = 0;
        first_rd_cyc = -1;
        done_cyc     = -1;
        last_hs_cyc  = -1;
        bp_cnt       = 0;
        rdy_mode     = mode;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    endtask

    // called at posedge+2 while idle; builds the model's expected stream
    task automatic start_pulse(input int sa, input int len);
        int n;
        n = (len > 256) ? 256 : len;
        for (int i = 0; i < n; i++) exp_q.push_back({8'((sa + i) % 256), mem[(sa + i) % 256]});
        start      = 1'b1;
        start_addr = 8'(sa);
        length     = 9'(len);
        start_cyc  = cyc;
    endtask

    // poke: 0 none, 1 start pulse mid-dump, 2 start pulse during the done cycle
    task automatic run_dump(input int sa, input int len, input int mode, input int poke);
        int  n;
        bit  poked;
        int  guard;
        n     = (len > 256) ? 256 : len;
        poked = 0;
        @(posedge clk); #2;
        init_dump(mode);
        start_pulse(sa, len);
        guard = 0;
        while (1) begin
            @(posedge clk); #2;
            start = 1'b0;
            guard++;
            if (done_cnt != 0) break;
            if (guard > 20 * n + 50) begin
                check("dump_timeout", 0, 1);
                break;
            end
            if (poke == 1 && !poked && obs_q.size() >= 5) begin
                start      = 1'b1;
                start_addr = 8'($urandom_range(0, 255));
                length     = 9'($urandom_range(1, 50));
                poked      = 1;
            end
            if (poke == 2 && !poked && done) begin
                start      = 1'b1;
                start_addr = 8'h10;
                length     = 9'd3;
                poked      = 1;
            end
        end
        repeat (3) @(posedge clk);
        #2;
        check("stream_complete", exp_q.size(), 0);
        check("read_count", rd_cnt, n);
        check("done_count", done_cnt, 1);
        check("idle_after", int'(busy), 0);
        if (n == 0) check("zero_len_done_delay", done_cyc - start_cyc, 2);
        else        check("first_read_delay", first_rd_cyc - start_cyc, 2);
        if (mode == 0) check("busy_cycles", busy_cnt, 3 * n + 1);
    endtask

    initial begin
        int guard;
        reset      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[3] = 8'd12;
        mem[4] = 8'd4;
        mem[8] = 8'hA5;
        init_dump(0);

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy",      int'(busy), 0);
        check("rst_done",      int'(done), 0);
        check("rst_mem_rd",    int'(bus.mem_rd), 0);
        check("rst_mem_addr",  int'(bus.mem_addr), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data",  int'(bus.out_data), 0);
        check("rst_out_addr",  int'(bus.out_addr), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // basic dump
        run_dump(3, 2, 0, 0);
        check("basic_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("basic_b0", int'(obs_q[0]), int'({8'd3, 8'd12}));
            check("basic_b1", int'(obs_q[1]), int'({8'd4, 8'd4}));
        end

        // backpressure on the first byte
        run_dump(20, 3, 2, 0);
        check("bp_stall_cycles", stall_cnt, 5);
        check("bp_count", obs_q.size(), 3);

        // wrap, plus a start during the done cycle that must be ignored
        run_dump(254, 4, 0, 2);
        check("wrap_count", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("wrap_a0", int'(obs_q[0][15:8]), 254);
            check("wrap_a1", int'(obs_q[1][15:8]), 255);
            check("wrap_a2", int'(obs_q[2][15:8]), 0);
            check("wrap_a3", int'(obs_q[3][15:8]), 1);
        end
        repeat (4) @(posedge clk);
        #2;
        check("finish_start_ignored_rd", rd_cnt, 4);
        check("finish_start_ignored_busy", int'(busy), 0);

        // wrap example from 250
        run_dump(250, 10, 0, 0);
        if (obs_q.size() == 10) begin
            check("wrap250_a5", int'(obs_q[5][15:8]), 255);
            check("wrap250_a6", int'(obs_q[6][15:8]), 0);
            check("wrap250_a9", int'(obs_q[9][15:8]), 3);
        end

        // zero length
        run_dump(77, 0, 0, 0);
        check("zero_len_bytes", obs_q.size(), 0);

        // clamp and ignored start mid-dump
        run_dump(0, 300, 0, 1);
        check("clamp_count", obs_q.size(), 256);
        if (obs_q.size() == 256) begin
            check("clamp_first", int'(obs_q[0][15:8]), 0);
            check("clamp_last", int'(obs_q[255][15:8]), 255);
        end

        // reset abort during HOLD of byte 2 of 5
        @(posedge clk); #2;
        init_dump(0);
        start_pulse(40, 5);
        guard = 0;
        while (1) begin
            @(posedge clk); #2;
            start = 1'b0;
            guard++;
            if (bus.out_valid && obs_q.size() == 1) break;
            if (guard > 100) begin
                check("abort_timeout", 0, 1);
                break;
            end
        end
        reset = 1'b0;
        #1;
        check("abort_busy",      int'(busy), 0);
        check("abort_done",      int'(done), 0);
        check("abort_mem_rd",    int'(bus.mem_rd), 0);
        check("abort_mem_addr",  int'(bus.mem_addr), 0);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_out_data",  int'(bus.out_data), 0);
        check("abort_out_addr",  int'(bus.out_addr), 0);
        repeat (3) @(posedge clk);
        check("abort_no_done", done_cnt, 0);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        run_dump(8, 1, 0, 0);
        check("after_abort_count", obs_q.size(), 1);
        if (obs_q.size() == 1) check("after_abort_b0", int'(obs_q[0]), int'({8'd8, 8'hA5}));

        // randomized dumps
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            run_dump($urandom_range(0, 255),
                     (k % 3 == 0) ? $urandom_range(256, 511) : $urandom_range(0, 40),
                     $urandom_range(0, 1), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter: ADDR_W, default 8, memory address width (256 locations).
REQ-002 Parameter: DATA_W, default 8, memory and stream data width.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  dump request; sampled only in IDLE.
REQ-006 Port: start_addr  input  ADDR_W  first memory address to read; captured on accepted start.
REQ-007 Port: length  input  ADDR_W+1  number of bytes to dump, 0..256; captured on accepted start.
REQ-008 Port: mem_rd  output  1  read strobe to the data-memory read port.
REQ-009 Port: mem_addr  output  ADDR_W  read address, valid while mem_rd=1.
REQ-010 Port: mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd=1.
REQ-011 Port: out_valid  output  1  stream byte available.
REQ-012 Port: out_data  output  DATA_W  stream byte.
REQ-013 Port: out_addr  output  ADDR_W  memory address the stream byte was read from.
REQ-014 Port: out_ready  input  1  downstream accepts the byte when out_valid=1 and out_ready=1.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: done  output  1  one-cycle pulse when a dump completes.

Function
REQ-017 FSM states: IDLE, READ, CAPTURE, HOLD, FINISH.
REQ-018 IDLE: on start=1, latch addr<=start_addr and remaining<=min(length,256); go to READ if length!=0, else go to FINISH.
REQ-019 READ: mem_rd=1 and mem_addr=addr for exactly one cycle; next state CAPTURE.
REQ-020 CAPTURE: latch mem_rdata into out_data and addr into out_addr; set out_valid=1; decrement remaining; increment addr modulo 2^ADDR_W; next state HOLD.
REQ-021 HOLD: out_valid=1 with out_data and out_addr stable until handshake; on out_valid&&out_ready, clear out_valid and go to READ if remaining!=0, else go to FINISH.
REQ-022 FINISH: done=1 for exactly one cycle; next state IDLE.
REQ-023 Minimum throughput with out_ready held high is one byte per 3 cycles; a byte appears on out_valid 2 cycles after its READ cycle.
REQ-024 Address wraps 255->0 without error; start_addr=250, length=10 reads 250..255 then 0..3.
REQ-025 length values above 256 are clamped to 256; the same location is never read twice in one dump.
REQ-026 start while busy=1 is ignored and does not alter addr, remaining, or the current transfer.
REQ-027 mem_rd is never asserted outside READ; out_valid never deasserts without a handshake except by reset.
REQ-028 start asserted during the FINISH cycle is ignored; start is accepted from the cycle after done.

Reset
REQ-029 While reset=0: state=IDLE; mem_rd=0, mem_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0; addr and remaining=0.
REQ-030 Reset asserted mid-dump aborts the dump immediately, with no done pulse; a subsequent start begins a fresh dump.

Verification
REQ-031 Basic dump: mem[3]=12, mem[4]=4, start_addr=3, length=2, out_ready=1 -> stream (3,12), (4,4); one done pulse; exactly 2 mem_rd pulses.
REQ-032 Backpressure: out_ready=0 for 5 cycles after the first out_valid -> out_data and out_addr held constant across all 5 cycles; no extra mem_rd pulses; the byte is transferred once when out_ready rises.
REQ-033 Wrap: start_addr=254, length=4 -> out_addr sequence 254, 255, 0, 1.
REQ-034 Zero length: start with length=0 -> no mem_rd, no out_valid; done pulses 2 cycles after start; busy high for 1 cycle.
REQ-035 Start while busy and clamp: start_addr=0, length=300 -> exactly 256 bytes with addresses 0..255; a second start mid-dump is ignored.
REQ-036 Reset abort: reset=0 asserted during HOLD of byte 2 of 5 -> all outputs 0 asynchronously; no done pulse; after release, start_addr=8, length=1 streams (8, mem[8]).
